// File: rtl/reorder_buffer.sv
// reorder_buffer: gathers one word per channel per frame in any arrival
// order and replays each frame as an index-ordered {index,data} stream.
// Up to F complete frames are buffered so filling and draining overlap.
module reorder_buffer #(
  parameter int W = 8,
  parameter int N = 4,
  parameter int F = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           s_stb,
  input  logic [N*W-1:0]         s_dat,
  output logic [N-1:0]           s_rdy,
  input  logic                   m_rdy,
  output logic                   m_stb,
  output logic [$clog2(N)+W-1:0] m_dat,
  output logic                   m_last,
  output logic [$clog2(F+1)-1:0] level
);
  localparam int IW = $clog2(N);
  localparam int PW = (F > 1) ? $clog2(F) : 1;
  localparam int CW = $clog2(F+1);
  localparam int AW = $clog2(F*N);

  logic [W-1:0]    mem_q [F*N];
  logic [PW-1:0]   wf_q, rf_q;
  logic [N-1:0]    recv_q;
  logic [CW-1:0]   cnt_q;
  logic [IW-1:0]   ridx_q;
  logic            m_stb_q, m_last_q;
  logic [IW+W-1:0] m_dat_q;

  logic [N-1:0]  grant;
  logic [IW-1:0] acc_idx;
  logic [W-1:0]  acc_dat;
  logic          acc, full, frame_done, load, rel;
  logic [AW-1:0] wr_addr, rd_addr;

  assign full = (cnt_q == CW'(F));

  // Lowest-index eligible channel gets the single write grant this cycle
  always_comb begin
    grant   = '0;
    acc_idx = '0;
    acc_dat = '0;
    acc     = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!acc && s_stb[i] && !recv_q[i] && !full && !rst) begin
        grant[i] = 1'b1;
        acc_idx  = IW'(i);
        acc_dat  = s_dat[i*W +: W];
        acc      = 1'b1;
      end
    end
  end

  assign s_rdy      = grant;
  assign frame_done = acc && ((recv_q | grant) == {N{1'b1}});
  assign wr_addr    = AW'(int'(wf_q) * N + int'(acc_idx));
  assign rd_addr    = AW'(int'(rf_q) * N + int'(ridx_q));

  // Output register refills whenever it is empty or being consumed
  assign load = (cnt_q != '0) && (!m_stb_q || m_rdy);
  assign rel  = load && (ridx_q == IW'(N-1));

  // Frame storage; contents need no reset since recv/cnt gate all use
  always_ff @(posedge clk) begin
    if (acc) mem_q[wr_addr] <= acc_dat;
  end

  // Write/read pointers, receive mask, frame count and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      wf_q     <= '0;
      rf_q     <= '0;
      recv_q   <= '0;
      cnt_q    <= '0;
      ridx_q   <= '0;
      m_stb_q  <= 1'b0;
      m_last_q <= 1'b0;
      m_dat_q  <= '0;
    end else begin
      if (acc) begin
        if (frame_done) begin
          recv_q <= '0;
          wf_q   <= (wf_q == PW'(F-1)) ? '0 : wf_q + 1'b1;
        end else begin
          recv_q <= recv_q | grant;
        end
      end
      if (frame_done && !rel)      cnt_q <= cnt_q + 1'b1;
      else if (!frame_done && rel) cnt_q <= cnt_q - 1'b1;
      if (load) begin
        m_dat_q  <= {ridx_q, mem_q[rd_addr]};
        m_last_q <= (ridx_q == IW'(N-1));
        m_stb_q  <= 1'b1;
        if (rel) begin
          ridx_q <= '0;
          rf_q   <= (rf_q == PW'(F-1)) ? '0 : rf_q + 1'b1;
        end else begin
          ridx_q <= ridx_q + 1'b1;
        end
      end else if (m_stb_q && m_rdy) begin
        m_stb_q <= 1'b0;
      end
    end
  end

  assign m_stb  = m_stb_q;
  assign m_dat  = m_dat_q;
  assign m_last = m_last_q;
  assign level  = cnt_q;
endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: N=4/F=2 main instance plus an N=3/F=3 instance
// for non-power-of-2 wrap. Expected words are queued as frames are driven.
module tb_reorder_buffer;
  typedef logic [10:0] exp_t; // {last, index, data}

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0]  s_stb, s_rdy;
  logic [31:0] s_dat;
  logic        m_rdy, m_stb, m_last;
  logic [9:0]  m_dat;
  logic [1:0]  level;

  logic [2:0]  s_stb2, s_rdy2;
  logic [23:0] s_dat2;
  logic        m_rdy2, m_stb2, m_last2;
  logic [9:0]  m_dat2;
  logic [1:0]  level2;

  reorder_buffer #(.W(8), .N(4), .F(2)) dut (
    .clk(clk), .rst(rst), .s_stb(s_stb), .s_dat(s_dat), .s_rdy(s_rdy),
    .m_rdy(m_rdy), .m_stb(m_stb), .m_dat(m_dat), .m_last(m_last), .level(level));

  reorder_buffer #(.W(8), .N(3), .F(3)) dut2 (
    .clk(clk), .rst(rst), .s_stb(s_stb2), .s_dat(s_dat2), .s_rdy(s_rdy2),
    .m_rdy(m_rdy2), .m_stb(m_stb2), .m_dat(m_dat2), .m_last(m_last2), .level(level2));

  int   chk = 0, pass = 0;
  int   cyc = 0, xfers = 0, gaps = 0, last_x = 0;
  exp_t sb[$], sb2[$];
  exp_t e1, e2;
  bit   rnd_en = 1'b0;

  always @(posedge clk) cyc++;

  // Random consumer stall for the second instance
  always @(posedge clk) begin
    #1;
    if (rnd_en) m_rdy2 = 1'($urandom_range(0, 1));
  end

  // Scoreboard for the main instance, also tracking transfer gaps
  always @(negedge clk) begin
    if (!rst && m_stb && m_rdy) begin
      chk++;
      if (sb.size() == 0) $display("FAIL out1_extra got=%h exp=none", {m_last, m_dat});
      else begin
        e1 = sb.pop_front();
        if ({m_last, m_dat} !== e1) $display("FAIL out1_word got=%h exp=%h", {m_last, m_dat}, e1);
        else pass++;
      end
      if (xfers > 0 && cyc != last_x + 1) gaps++;
      xfers++;
      last_x = cyc;
    end
  end

  // Scoreboard for the N=3 instance
  always @(negedge clk) begin
    if (!rst && m_stb2 && m_rdy2) begin
      chk++;
      if (sb2.size() == 0) $display("FAIL out2_extra got=%h exp=none", {m_last2, m_dat2});
      else begin
        e2 = sb2.pop_front();
        if ({m_last2, m_dat2} !== e2) $display("FAIL out2_word got=%h exp=%h", {m_last2, m_dat2}, e2);
        else pass++;
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Offer one word on one channel, wait (bounded) for its grant, drop the strobe
  task automatic send(input int ch, input logic [7:0] d);
    int n;
    n = 0;
    s_stb = 4'b0001 << ch;
    s_dat[ch*8 +: 8] = d;
    @(negedge clk);
    while (!s_rdy[ch] && n < 100) begin
      step();
      @(negedge clk);
      n++;
    end
    chk++;
    if (s_rdy !== (4'b0001 << ch)) $display("FAIL send_grant ch=%0d got=%b exp=%b", ch, s_rdy, 4'b0001 << ch);
    else pass++;
    step();
    s_stb = '0;
  endtask

  // ord holds 4 channel numbers (2 bits each, first at LSB); dw holds per-channel data
  task automatic send_frame(input logic [7:0] ord, input logic [31:0] dw);
    for (int k = 0; k < 4; k++) begin
      int ch;
      ch = int'(ord[k*2 +: 2]);
      send(ch, dw[ch*8 +: 8]);
    end
    for (int i = 0; i < 4; i++) sb.push_back({i == 3, 2'(i), dw[i*8 +: 8]});
  endtask

  task automatic send2(input int ch, input logic [7:0] d);
    int n;
    n = 0;
    s_stb2 = 3'b001 << ch;
    s_dat2[ch*8 +: 8] = d;
    @(negedge clk);
    while (!s_rdy2[ch] && n < 100) begin
      step();
      @(negedge clk);
      n++;
    end
    chk++;
    if (s_rdy2 !== (3'b001 << ch)) $display("FAIL send2_grant ch=%0d got=%b exp=%b", ch, s_rdy2, 3'b001 << ch);
    else pass++;
    step();
    s_stb2 = '0;
  endtask

  task automatic wait_drain;
    int n;
    n = 0;
    while ((sb.size() != 0 || sb2.size() != 0) && n < 300) begin
      step();
      n++;
    end
    repeat (3) step();
  endtask

  task automatic test_reset;
    rst = 1'b1; s_stb = 4'hF; s_stb2 = 3'h7; s_dat = '0; s_dat2 = '0;
    m_rdy = 1'b0; m_rdy2 = 1'b0;
    step(); step();
    @(negedge clk);
    chk++; if (s_rdy !== 4'h0)   $display("FAIL rst_srdy got=%b exp=0000", s_rdy); else pass++;
    chk++; if (s_rdy2 !== 3'h0)  $display("FAIL rst_srdy2 got=%b exp=000", s_rdy2); else pass++;
    chk++; if ({m_stb, m_last} !== 2'b00) $display("FAIL rst_mstb got=%b exp=00", {m_stb, m_last}); else pass++;
    chk++; if (m_dat !== 10'h0)  $display("FAIL rst_mdat got=%h exp=000", m_dat); else pass++;
    chk++; if (level !== 2'd0)   $display("FAIL rst_level got=%0d exp=0", level); else pass++;
    chk++; if (m_stb2 !== 1'b0)  $display("FAIL rst_mstb2 got=%b exp=0", m_stb2); else pass++;
    step();
    rst = 1'b0; s_stb = '0; s_stb2 = '0;
    step();
  endtask

  task automatic test_order_latency;
    m_rdy = 1'b1;
    send_frame({2'd1, 2'd3, 2'd0, 2'd2}, 32'hD3C2B1A0); // order 2,0,3,1
    chk++; if (level !== 2'd1) $display("FAIL lat_level_T got=%0d exp=1", level); else pass++;
    chk++; if (m_stb !== 1'b0) $display("FAIL lat_mstb_T got=%b exp=0", m_stb); else pass++;
    step();
    chk++; if (m_stb !== 1'b1) $display("FAIL lat_mstb_T1 got=%b exp=1", m_stb); else pass++;
    step(); step();
    chk++; if (level !== 2'd1) $display("FAIL lat_level_T3 got=%0d exp=1", level); else pass++;
    step();
    chk++; if (level !== 2'd0) $display("FAIL lat_level_T4 got=%0d exp=0", level); else pass++;
    chk++; if (m_last !== 1'b1) $display("FAIL lat_mlast_T4 got=%b exp=1", m_last); else pass++;
    wait_drain();
  endtask

  task automatic test_back_to_back;
    m_rdy = 1'b1;
    s_dat = 32'h44332211;
    s_stb = 4'hF;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk++;
      if (s_rdy !== (4'b0001 << (i % 4))) $display("FAIL b2b_grant i=%0d got=%b exp=%b", i, s_rdy, 4'b0001 << (i % 4));
      else pass++;
      if (i >= 5) begin
        chk++; if (m_stb !== 1'b1) $display("FAIL b2b_stream i=%0d got=%b exp=1", i, m_stb); else pass++;
      end
      step();
      if (i == 3 || i == 7)
        for (int j = 0; j < 4; j++) sb.push_back({j == 3, 2'(j), s_dat[j*8 +: 8]});
    end
    s_stb = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk++; if (m_stb !== 1'b1) $display("FAIL b2b_tail i=%0d got=%b exp=1", i, m_stb); else pass++;
      step();
    end
    wait_drain();
  endtask

  task automatic test_holdoff;
    m_rdy = 1'b1;
    s_stb = 4'b0010; s_dat[15:8] = 8'h11;
    @(negedge clk);
    chk++; if (s_rdy !== 4'b0010) $display("FAIL hold_first got=%b exp=0010", s_rdy); else pass++;
    step();
    s_dat[15:8] = 8'h22; s_dat[7:0] = 8'h10; s_stb = 4'b0011;
    @(negedge clk);
    chk++; if (s_rdy !== 4'b0001) $display("FAIL hold_ch1_blocked got=%b exp=0001", s_rdy); else pass++;
    step();
    s_dat[23:16] = 8'h12; s_stb = 4'b0110;
    @(negedge clk);
    chk++; if (s_rdy !== 4'b0100) $display("FAIL hold_ch2 got=%b exp=0100", s_rdy); else pass++;
    step();
    s_dat[31:24] = 8'h13; s_stb = 4'b1010;
    @(negedge clk);
    chk++; if (s_rdy !== 4'b1000) $display("FAIL hold_ch3 got=%b exp=1000", s_rdy); else pass++;
    step();
    sb.push_back({1'b0, 2'd0, 8'h10}); sb.push_back({1'b0, 2'd1, 8'h11});
    sb.push_back({1'b0, 2'd2, 8'h12}); sb.push_back({1'b1, 2'd3, 8'h13});
    s_stb = 4'b0010;
    @(negedge clk);
    chk++; if (s_rdy !== 4'b0010) $display("FAIL hold_next_frame got=%b exp=0010", s_rdy); else pass++;
    step();
    s_stb = '0;
    send(0, 8'h20); send(3, 8'h26); send(2, 8'h24);
    sb.push_back({1'b0, 2'd0, 8'h20}); sb.push_back({1'b0, 2'd1, 8'h22});
    sb.push_back({1'b0, 2'd2, 8'h24}); sb.push_back({1'b1, 2'd3, 8'h26});
    wait_drain();
  endtask

  task automatic test_full;
    m_rdy = 1'b0;
    send_frame({2'd3, 2'd2, 2'd1, 2'd0}, 32'h83828180);
    send_frame({2'd0, 2'd1, 2'd2, 2'd3}, 32'h93929190);
    chk++; if (level !== 2'd2) $display("FAIL full_level got=%0d exp=2", level); else pass++;
    s_stb = 4'b0001; s_dat[7:0] = 8'hA0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk++; if (s_rdy !== 4'h0) $display("FAIL full_blocked i=%0d got=%b exp=0000", i, s_rdy); else pass++;
      step();
    end
    s_stb = '0;
    xfers = 0; gaps = 0;
    m_rdy = 1'b1;
    send_frame({2'd1, 2'd0, 2'd3, 2'd2}, 32'hA3A2A1A0);
    wait_drain();
    chk++; if (xfers !== 12) $display("FAIL full_count got=%0d exp=12", xfers); else pass++;
    chk++; if (gaps !== 0)   $display("FAIL full_gaps got=%0d exp=0", gaps); else pass++;
  endtask

  task automatic test_wrap_n3;
    int p[3];
    int t, r;
    logic [7:0] d [3];
    rnd_en = 1'b1;
    for (int f = 0; f < 10; f++) begin
      p[0] = 0; p[1] = 1; p[2] = 2;
      for (int k = 2; k > 0; k--) begin
        r = int'($urandom_range(0, k));
        t = p[k]; p[k] = p[r]; p[r] = t;
      end
      for (int i = 0; i < 3; i++) d[i] = 8'($urandom);
      for (int k = 0; k < 3; k++) send2(p[k], d[p[k]]);
      for (int i = 0; i < 3; i++) sb2.push_back({i == 2, 2'(i), d[i]});
    end
    wait_drain();
    rnd_en = 1'b0;
    step();
    m_rdy2 = 1'b1;
    chk++; if (sb2.size() !== 0) $display("FAIL n3_drain got=%0d exp=0", sb2.size()); else pass++;
  endtask

  task automatic test_reset_mid;
    m_rdy = 1'b0;
    send_frame({2'd3, 2'd2, 2'd1, 2'd0}, 32'hB3B2B1B0);
    send(0, 8'hC0); send(1, 8'hC1);
    rst = 1'b1; s_stb = 4'hF;
    @(negedge clk);
    chk++; if (s_rdy !== 4'h0) $display("FAIL rstmid_srdy got=%b exp=0000", s_rdy); else pass++;
    step();
    rst = 1'b0; s_stb = '0;
    sb.delete();
    chk++; if (m_stb !== 1'b0) $display("FAIL rstmid_mstb got=%b exp=0", m_stb); else pass++;
    chk++; if (level !== 2'd0) $display("FAIL rstmid_level got=%0d exp=0", level); else pass++;
    m_rdy = 1'b1;
    send_frame({2'd2, 2'd0, 2'd3, 2'd1}, 32'hD3D2D1D0);
    wait_drain();
    chk++; if (sb.size() !== 0) $display("FAIL rstmid_drain got=%0d exp=0", sb.size()); else pass++;
  endtask

  initial begin
    test_reset();
    test_order_latency();
    test_back_to_back();
    test_holdoff();
    test_full();
    test_wrap_n3();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end
endmodule
